// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC select, runs the req/ack handshake with
// instruction memory and buffers fetched words with their addresses for decode.
module fetch_unit #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [1:0]  pc_ps,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [1:0]  redirect_ps
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_STALL = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_REDIR = 3'd4;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;

   logic [2:0]       state, state_nxt;
   logic [31:0]      fetch_addr, fetch_addr_nxt;
   logic [CNT_W-1:0] count, count_push;
   logic [PTR_W-1:0] head, tail;
   logic [31:0]      buf_data [DEPTH];
   logic [31:0]      buf_addr [DEPTH];
   logic             push, pop, flush;
   logic [1:0]       ps;

   // Next-state, fetch address, buffer control and PC select
   always_comb begin
      state_nxt      = state;
      fetch_addr_nxt = fetch_addr;
      push           = 1'b0;
      flush          = 1'b0;
      ps             = PS_HOLD;
      pop            = (count != '0) && ir_ready && !redirect;
      count_push     = count + CNT_W'(1) - CNT_W'(pop);

      if (redirect) begin
         ps    = redirect_ps;
         flush = 1'b1;
         // An unacked request must complete before the target can be fetched
         case (state)
            ST_REQ, ST_DRAIN: state_nxt = mem_ack ? ST_REDIR : ST_DRAIN;
            default:          state_nxt = ST_REDIR;
         endcase
      end else begin
         case (state)
            ST_IDLE: begin
               fetch_addr_nxt = pc;
               state_nxt      = ST_REQ;
            end
            ST_REQ: begin
               if (mem_ack) begin
                  push           = 1'b1;
                  ps             = PS_INC;
                  fetch_addr_nxt = fetch_addr + 32'd1;
                  state_nxt      = (count_push < CNT_W'(DEPTH)) ? ST_REQ : ST_STALL;
               end
            end
            ST_STALL: begin
               if (pop) state_nxt = ST_REQ;
            end
            ST_DRAIN: begin
               if (mem_ack) begin
                  fetch_addr_nxt = pc;
                  state_nxt      = ST_REQ;
               end
            end
            ST_REDIR: begin
               fetch_addr_nxt = pc;
               state_nxt      = ST_REQ;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         fetch_addr <= '0;
         mem_req    <= 1'b0;
         count      <= '0;
         head       <= '0;
         tail       <= '0;
      end else begin
         state      <= state_nxt;
         fetch_addr <= fetch_addr_nxt;
         mem_req    <= (state_nxt == ST_REQ) || (state_nxt == ST_DRAIN);
         if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
         end else begin
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
         end
      end
   end

   // Buffer storage needs no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[tail] <= mem_rdata;
         buf_addr[tail] <= fetch_addr;
      end
   end

   assign mem_addr = fetch_addr;
   assign ir_valid = (count != '0);
   assign ir       = ir_valid ? buf_data[head] : '0;
   assign ir_pc    = ir_valid ? buf_addr[head] : '0;
   assign pc_ps    = rst ? ps : PS_HOLD;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a PC model, a memory model and a
// scoreboard of expected decode-side instructions.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [1:0]  pc_ps;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect;
   logic [1:0]  redirect_ps;

   logic        pc_load_en;
   logic [31:0] pc_load_val;
   logic [31:0] load_target;
   logic [31:0] offset;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   fetch_unit #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_ps(pc_ps),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect(redirect), .redirect_ps(redirect_ps)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a ^ 32'h5A5A_0000) + 32'h0000_1000;
   endfunction

   assign mem_rdata = word_of(mem_addr);

   // Simple program_counter model driven by pc_ps
   always @(posedge clk) begin
      if (pc_load_en) pc <= pc_load_val;
      else case (pc_ps)
         2'b01:   pc <= pc + 32'd1;
         2'b10:   pc <= load_target;
         2'b11:   pc <= pc + offset;
         default: pc <= pc;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Decode side: every accepted instruction must match the next scoreboard entry
   always @(negedge clk) begin
      if (rst && ir_valid && ir_ready && !redirect) begin
         if (sb.size() == 0) check("sb_unexpected_pop", 32'(sb.size()), 32'd1);
         else begin
            logic [31:0] a;
            a = sb.pop_front();
            check("pop_ir_pc", ir_pc, a);
            check("pop_ir", ir, word_of(a));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; pc_load_en = 1'b1; pc_load_val = 32'h100;
      mem_ack = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_ps = 2'b00;
      load_target = 32'h0; offset = 32'h0;
      repeat (3) step();
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_ir", ir, 32'h0);
      check("rst_pc_ps", 32'(pc_ps), 32'd0);

      // Streaming fetch with ack always high
      step(); rst = 1'b1; pc_load_en = 1'b0; mem_ack = 1'b1; #1;
      check("idle_pc_ps", 32'(pc_ps), 32'd0);
      sb.push_back(32'h100); sb.push_back(32'h101); sb.push_back(32'h102);
      step(); #1;
      check("s1_req", 32'(mem_req), 32'd1);
      check("s1_addr", mem_addr, 32'h100);
      check("s1_ps", 32'(pc_ps), 32'd1);
      check("s1_valid", 32'(ir_valid), 32'd0);
      step(); #1;
      check("s2_addr", mem_addr, 32'h101);
      check("s2_ps", 32'(pc_ps), 32'd1);
      check("s2_ir_pc", ir_pc, 32'h100);
      step(); #1;
      check("s3_addr", mem_addr, 32'h102);
      check("s3_ir_pc", ir_pc, 32'h101);
      step(); mem_ack = 1'b0; #1;
      check("s4_addr", mem_addr, 32'h103);
      check("s4_ir_pc", ir_pc, 32'h102);
      check("s4_ps_noack", 32'(pc_ps), 32'd0);

      // Fill the buffer with decode stalled
      step(); ir_ready = 1'b0; mem_ack = 1'b1; #1;
      sb.push_back(32'h103);
      check("f5_valid", 32'(ir_valid), 32'd0);
      check("f5_ps", 32'(pc_ps), 32'd1);
      step(); #1;
      check("f6_addr", mem_addr, 32'h104);
      check("f6_valid", 32'(ir_valid), 32'd1);
      step(); #1;
      check("stall_req", 32'(mem_req), 32'd0);
      check("stall_ps", 32'(pc_ps), 32'd0);
      check("stall_addr", mem_addr, 32'h105);
      step(); ir_ready = 1'b1; mem_ack = 1'b0; #1;
      check("stall2_req", 32'(mem_req), 32'd0);

      // Redirect while the request to 0x105 is outstanding
      step(); ir_ready = 1'b0; redirect = 1'b1; redirect_ps = 2'b10; load_target = 32'h400; #1;
      check("unstall_req", 32'(mem_req), 32'd1);
      check("unstall_addr", mem_addr, 32'h105);
      check("unstall_ir_pc", ir_pc, 32'h104);
      check("redir_ps_load", 32'(pc_ps), 32'd2);
      step(); redirect = 1'b0; #1;
      check("drain_addr", mem_addr, 32'h105);
      check("drain_req", 32'(mem_req), 32'd1);
      check("drain_flush", 32'(ir_valid), 32'd0);
      check("drain_ps", 32'(pc_ps), 32'd0);
      step(); #1;
      check("drain2_addr", mem_addr, 32'h105);
      step(); mem_ack = 1'b1; #1;
      check("drain_ack_ps", 32'(pc_ps), 32'd0);
      step(); #1;
      check("post_drain_addr", mem_addr, 32'h400);
      check("post_drain_req", 32'(mem_req), 32'd1);
      check("post_drain_valid", 32'(ir_valid), 32'd0);

      // Redirect in the same cycle as an ack: word is dropped
      step(); redirect = 1'b1; redirect_ps = 2'b10; load_target = 32'h800; #1;
      check("r_ir_pc", ir_pc, 32'h400);
      check("r_ir", ir, word_of(32'h400));
      check("r_ps_prio", 32'(pc_ps), 32'd2);
      step(); redirect = 1'b0; ir_ready = 1'b1; #1;
      check("redir_state_req", 32'(mem_req), 32'd0);
      check("redir_state_valid", 32'(ir_valid), 32'd0);
      check("redir_state_ps", 32'(pc_ps), 32'd0);
      step(); #1;
      check("tgt_addr", mem_addr, 32'h800);
      check("tgt_req", 32'(mem_req), 32'd1);

      // Simultaneous push and pop at count 1
      sb.push_back(32'h800); sb.push_back(32'h801);
      step(); #1;
      check("pp_ir_pc0", ir_pc, 32'h800);
      step(); mem_ack = 1'b0; #1;
      check("pp_ir_pc1", ir_pc, 32'h801);
      check("pp_valid", 32'(ir_valid), 32'd1);

      // Reset asserted while draining
      step(); redirect = 1'b1; redirect_ps = 2'b11; offset = 32'h10; #1;
      check("pp_empty", 32'(ir_valid), 32'd0);
      check("off_ps", 32'(pc_ps), 32'd3);
      step(); redirect = 1'b0; rst = 1'b0; #1;
      check("d_addr", mem_addr, 32'h802);
      check("d_req", 32'(mem_req), 32'd1);
      check("d_rst_ps", 32'(pc_ps), 32'd0);
      step(); rst = 1'b1; #1;
      check("mrst_req", 32'(mem_req), 32'd0);
      check("mrst_valid", 32'(ir_valid), 32'd0);
      check("mrst_addr", mem_addr, 32'h0);
      check("mrst_ps", 32'(pc_ps), 32'd0);
      step(); #1;
      check("restart_req", 32'(mem_req), 32'd1);
      check("restart_addr", mem_addr, 32'h812);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
